axil_router_rd: RTL
===================

// Module: axil_router_rd
// PURPOSE
//  AXI4-Lite read-channel router: 1 master port to SLV_NUM slave ports, selected by a parametrised address map.
//  Registered, one-outstanding-transaction routing; unmapped addresses are answered locally with DECERR.
//  Sits in the interconnect read path after the priority arbiter; successor of the fixed 2-way valid/invalid read mux.
// PARAMETERS
//  AXI_DATA_WIDTH  32                 rdata width (bits)
//  AXI_ADDR_WIDTH  32                 araddr width (bits)
//  SLV_NUM         4                  number of slave ports, 1..16
//  SLV_BASE_ADDR   {SLV_NUM{'0}}      per-slave base address, [SLV_NUM][AXI_ADDR_WIDTH]
//  SLV_ADDR_MASK   {SLV_NUM{'0}}      per-slave compare mask; hit if (araddr & mask) == (base & mask)
//  ERR_CNT_WIDTH   16                 width of decode-error counter
// PORTS
//  aclk             in   1                       clock
//  areset           in   1                       reset, asynchronous, active-high
//  s_axil_araddr    in   AXI_ADDR_WIDTH          master read address
//  s_axil_arvalid   in   1                       master address valid
//  s_axil_arready   out  1                       router ready for address
//  s_axil_rdata     out  AXI_DATA_WIDTH          read data to master
//  s_axil_rresp     out  2                       read response to master
//  s_axil_rvalid    out  1                       read data valid to master
//  s_axil_rready    in   1                       master ready for data
//  m_axil_araddr    out  SLV_NUM*AXI_ADDR_WIDTH  per-slave address (slice i = slave i)
//  m_axil_arvalid   out  SLV_NUM                 per-slave address valid
//  m_axil_arready   in   SLV_NUM                 per-slave address ready
//  m_axil_rdata     in   SLV_NUM*AXI_DATA_WIDTH  per-slave read data
//  m_axil_rresp     in   SLV_NUM*2               per-slave response
//  m_axil_rvalid    in   SLV_NUM                 per-slave data valid
//  m_axil_rready    out  SLV_NUM                 per-slave data ready
//  decerr_cnt       out  ERR_CNT_WIDTH           saturating count of DECERR responses issued
// BEHAVIOUR
//  FSM states IDLE, ADDR, DATA, ERR; areset -> IDLE, sel_q=0, addr_q=0, decerr_cnt=0.
//  All outputs 0 while areset high (s_axil_arready included); unselected slave ports are always driven 0.
//  IDLE: s_axil_arready=1. On arvalid&arready, register addr_q=araddr; decode:
//    hit -> sel_q = lowest matching index, go ADDR; no hit -> go ERR.
//  ADDR: m_axil_arvalid[sel_q]=1, m_axil_araddr[sel_q]=addr_q (1 cycle after master handshake);
//    stay until m_axil_arready[sel_q]=1, then go DATA. s_axil_arready=0.
//  DATA: s_axil_rdata/rresp/rvalid = slave sel_q combinationally; m_axil_rready[sel_q]=s_axil_rready;
//    on m_axil_rvalid[sel_q]&s_axil_rready go IDLE. Slave rvalid arriving in ADDR is not forwarded before DATA.
//  ERR: s_axil_rvalid=1, s_axil_rresp=2'b11 (DECERR), s_axil_rdata='0; on s_axil_rready go IDLE,
//    decerr_cnt+=1, saturating at all-ones (no wrap).
//  Outside DATA/ERR: s_axil_rvalid=0, s_axil_rdata='0, s_axil_rresp=2'b00.
//  Overlapping windows: lowest index wins. Mask '0 on a slave matches every address.
//  Master address latency to slave: min 1 cycle; min round trip IDLE->IDLE: 3 cycles with 0-wait slave.
//  Back-to-back: next arready in cycle after R handshake (IDLE re-entered); no second outstanding read.
//  arvalid held across the R handshake cycle is not accepted that cycle (arready=0 outside IDLE).
//  Reset mid-transaction: immediate return to IDLE, all valids drop asynchronously; in-flight read is abandoned.
//  Assertions: at most one m_axil_arvalid/m_axil_rready bit high; s_axil_rvalid stable until rready.
// STRUCTURE
//  Package axil_ic_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, typedef enum rd_state_t
//    {IDLE,ADDR,DATA,ERR}; shared with future axil_router_wr.
//  Sub-module axil_addr_decoder (combinational): araddr -> hit, sel index; reused by write router.
//  Top: FSM + addr_q/sel_q registers + output demux/mux generate loops + decerr counter.
// TESTING
//  SLV_NUM=4, bases 0x0000_0000/0x1000_0000/0x2000_0000/0x3000_0000, mask 0xF000_0000.
//  1) Read 0x1000_0004, slave1 arready=1, rdata=0xCAFE_F00D OKAY -> master gets 0xCAFE_F00D/2'b00; only slave1 strobed.
//  2) Read 0x5000_0000 (unmapped) -> DECERR 2'b11, rdata 0, no slave arvalid; decerr_cnt 0->1.
//  3) Slave2 arready delayed 5 cycles, master rready low 3 cycles -> addr_q/rvalid held stable, single handshake each.
//  4) Back-to-back reads slave0 then slave3 -> second arready exactly 1 cycle after first R handshake; correct routing.
//  5) areset asserted during DATA (slave2 rvalid=1) -> all outputs 0 same cycle; after release arready=1, next read OK.
//  6) ERR_CNT_WIDTH=2, 5 unmapped reads -> decerr_cnt saturates at 3.

Source files
------------

// File: rtl/axil_ic_pkg.sv
// Shared definitions for the AXI4-Lite interconnect routers (read now, write later).
package axil_ic_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ERR
    } rd_state_t;

    // Width of a slave-select index; a single-slave router still needs one bit.
    function automatic int sel_width(input int slv_num);
        return (slv_num > 1) ? $clog2(slv_num) : 1;
    endfunction

endpackage

// File: rtl/axil_addr_decoder.sv
// Combinational address map lookup: reports whether an address hits any slave window
// and the lowest-indexed matching slave.
module axil_addr_decoder
    import axil_ic_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int SLV_NUM        = 4,
    parameter int SEL_W          = sel_width(SLV_NUM),
    parameter logic [SLV_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLV_BASE_ADDR = '0,
    parameter logic [SLV_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLV_ADDR_MASK = '0
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic                      hit,
    output logic [SEL_W-1:0]          sel
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        hit = 1'b0;
        sel = '0;
        for (int i = SLV_NUM - 1; i >= 0; i--) begin
            if ((addr & SLV_ADDR_MASK[i]) == (SLV_BASE_ADDR[i] & SLV_ADDR_MASK[i])) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/axil_router_rd.sv
// AXI4-Lite read router: one master port fanned out to SLV_NUM slaves, one read in flight,
// unmapped addresses answered locally with DECERR and counted.
module axil_router_rd
    import axil_ic_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int SLV_NUM        = 4,
    parameter logic [SLV_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLV_BASE_ADDR = '0,
    parameter logic [SLV_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLV_ADDR_MASK = '0,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [AXI_ADDR_WIDTH-1:0]         s_axil_araddr,
    input  logic                              s_axil_arvalid,
    output logic                              s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]         s_axil_rdata,
    output logic [1:0]                        s_axil_rresp,
    output logic                              s_axil_rvalid,
    input  logic                              s_axil_rready,
    output logic [SLV_NUM*AXI_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [SLV_NUM-1:0]                m_axil_arvalid,
    input  logic [SLV_NUM-1:0]                m_axil_arready,
    input  logic [SLV_NUM*AXI_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [SLV_NUM*2-1:0]              m_axil_rresp,
    input  logic [SLV_NUM-1:0]                m_axil_rvalid,
    output logic [SLV_NUM-1:0]                m_axil_rready,
    output logic [ERR_CNT_WIDTH-1:0]          decerr_cnt
);

    localparam int SEL_W = sel_width(SLV_NUM);

    rd_state_t                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [ERR_CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                      dec_hit;
    logic [SEL_W-1:0]          dec_sel;

    logic [AXI_DATA_WIDTH-1:0] slv_rdata [SLV_NUM];
    logic [1:0]                slv_rresp [SLV_NUM];

    axil_addr_decoder #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .SLV_NUM        (SLV_NUM),
        .SEL_W          (SEL_W),
        .SLV_BASE_ADDR  (SLV_BASE_ADDR),
        .SLV_ADDR_MASK  (SLV_ADDR_MASK)
    ) u_decoder (
        .addr (s_axil_araddr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // Reset forces state to IDLE asynchronously; arready is additionally held low during reset.
    assign s_axil_arready = (state_q == IDLE) && !areset;
    assign decerr_cnt     = cnt_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s_axil_arvalid) begin
                    addr_d = s_axil_araddr;
                    if (dec_hit) begin
                        sel_d   = dec_sel;
                        state_d = ADDR;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ADDR: if (m_axil_arready[sel_q]) state_d = DATA;
            DATA: if (m_axil_rvalid[sel_q] && s_axil_rready) state_d = IDLE;
            ERR: begin
                if (s_axil_rready) begin
                    state_d = IDLE;
                    if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-slave demux: only the selected port ever sees non-zero strobes or address.
    for (genvar g = 0; g < SLV_NUM; g++) begin : g_slv
        logic sel_hit;
        assign sel_hit = (sel_q == SEL_W'(g));

        assign m_axil_arvalid[g] = (state_q == ADDR) && sel_hit;
        assign m_axil_araddr[g*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] =
            ((state_q == ADDR) && sel_hit) ? addr_q : '0;
        assign m_axil_rready[g]  = (state_q == DATA) && sel_hit && s_axil_rready;

        assign slv_rdata[g] = m_axil_rdata[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign slv_rresp[g] = m_axil_rresp[g*2 +: 2];
    end

    // Upstream R mux; slave rvalid is only forwarded once the address phase has completed.
    always_comb begin
        s_axil_rdata  = '0;
        s_axil_rresp  = RESP_OKAY;
        s_axil_rvalid = 1'b0;
        case (state_q)
            DATA: begin
                s_axil_rdata  = slv_rdata[sel_q];
                s_axil_rresp  = slv_rresp[sel_q];
                s_axil_rvalid = m_axil_rvalid[sel_q];
            end
            ERR: begin
                s_axil_rresp  = RESP_DECERR;
                s_axil_rvalid = 1'b1;
            end
            default: ;
        endcase
    end

    a_one_arvalid: assert property (@(posedge aclk) disable iff (areset)
        $onehot0(m_axil_arvalid));
    a_one_rready: assert property (@(posedge aclk) disable iff (areset)
        $onehot0(m_axil_rready));
    a_rvalid_stable: assert property (@(posedge aclk) disable iff (areset)
        (s_axil_rvalid && !s_axil_rready) |=> s_axil_rvalid);

endmodule
